// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - opcodes, state encoding, IR fields and ALU op encoding for control_unit
package cu_pkg;

    localparam logic [4:0] OP_NOP = 5'd0;
    localparam logic [4:0] OP_MOV = 5'd1;
    localparam logic [4:0] OP_ADD = 5'd2;
    localparam logic [4:0] OP_SUB = 5'd3;
    localparam logic [4:0] OP_AND = 5'd4;
    localparam logic [4:0] OP_OR  = 5'd5;
    localparam logic [4:0] OP_LDI = 5'd6;
    localparam logic [4:0] OP_JMP = 5'd7;
    localparam logic [4:0] OP_JZ  = 5'd8;
    localparam logic [4:0] OP_HLT = 5'd31;

    typedef logic [2:0] state_t;
    localparam state_t ST_FETCH  = 3'd0;
    localparam state_t ST_DECODE = 3'd1;
    localparam state_t ST_READ_A = 3'd2;
    localparam state_t ST_READ_B = 3'd3;
    localparam state_t ST_EXEC   = 3'd4;
    localparam state_t ST_WB     = 3'd5;
    localparam state_t ST_HALT   = 3'd6;

    localparam int IR_OPC_LSB = 11;
    localparam int IR_RD_LSB  = 8;
    localparam int IR_RS_LSB  = 5;
    localparam int IR_IMM_LSB = 0;

    typedef logic [1:0] alu_op_t;
    localparam alu_op_t ALU_ADD = 2'd0;
    localparam alu_op_t ALU_SUB = 2'd1;
    localparam alu_op_t ALU_AND = 2'd2;
    localparam alu_op_t ALU_OR  = 2'd3;

    function automatic logic is_alu_op(input logic [4:0] opc);
        return (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND) || (opc == OP_OR);
    endfunction

    function automatic alu_op_t alu_op_of(input logic [4:0] opc);
        case (opc)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - program ROM and register_bank bus between control_unit and its neighbours
interface control_unit_if #(
    parameter int PC_WIDTH = 8
);
    logic [PC_WIDTH-1:0] prog_addr;
    logic [15:0]         prog_data;
    logic [2:0]          rb_selector;
    logic [7:0]          rb_in_data;
    logic                rb_write_en;
    logic                rb_read_en;
    logic [7:0]          rb_out_data;

    modport master (
        output prog_addr, rb_selector, rb_in_data, rb_write_en, rb_read_en,
        input  prog_data, rb_out_data
    );

    modport slave (
        input  prog_addr, rb_selector, rb_in_data, rb_write_en, rb_read_en,
        output prog_data, rb_out_data
    );
endinterface

// File: rtl/control_unit_alu.sv
// rtl/control_unit_alu.sv - combinational 8-bit ALU (ADD/SUB/AND/OR) with carry/borrow and zero
module alu
    import cu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [1:0] op,
    output logic [7:0] result,
    output logic       carry,
    output logic       zero
);
    logic [8:0] wide;

    // Bit 8 of the 9-bit difference is the borrow, set exactly when a < b.
    always_comb begin
        wide   = '0;
        result = '0;
        carry  = 1'b0;
        case (op)
            ALU_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[7:0];
                carry  = wide[8];
            end
            ALU_SUB: begin
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[7:0];
                carry  = wide[8];
            end
            ALU_AND: result = a & b;
            default: result = a | b;
        endcase
    end

    assign zero = (result == 8'h00);
endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle sequencer driving register_bank; ILLEGAL_OP_HALT_EN halts on illegal opcodes
module control_unit
    import cu_pkg::*;
#(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    control_unit_if.master bus,
    output logic           zero_flag,
    output logic           carry_flag,
    output logic           halted,
    output logic           illegal_op
);
    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc, jmp_target;
    logic [15:0]         ir_q, ir_d;
    logic [7:0]          a_q, a_d, b_q, b_d;
    logic                z_q, z_d, c_q, c_d;
    logic [4:0]          opc_ir, opc_rom;
    logic [2:0]          rd, rs;
    logic [7:0]          imm, alu_b, alu_result;
    logic                alu_carry, alu_zero;

    assign opc_ir     = ir_q[IR_OPC_LSB +: 5];
    assign opc_rom    = bus.prog_data[IR_OPC_LSB +: 5];
    assign rd         = ir_q[IR_RD_LSB +: 3];
    assign rs         = ir_q[IR_RS_LSB +: 3];
    assign imm        = ir_q[IR_IMM_LSB +: 8];
    assign pc_inc     = pc_q + PC_WIDTH'(1);
    assign jmp_target = PC_WIDTH'(bus.prog_data[IR_IMM_LSB +: 8]);

    // In EXEC the B operand is still on the bank's read port; afterwards it lives in b_q.
    assign alu_b = (state_q == ST_EXEC) ? bus.rb_out_data : b_q;

    alu u_alu (
        .a      (a_q),
        .b      (alu_b),
        .op     (alu_op_of(opc_ir)),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

`ifdef ILLEGAL_OP_HALT_EN
    logic ill_q, ill_d;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        z_d     = z_q;
        c_d     = c_q;
`ifdef ILLEGAL_OP_HALT_EN
        ill_d   = ill_q;
`endif
        case (state_q)
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                ir_d = bus.prog_data;
                case (opc_rom)
                    OP_NOP: begin
                        state_d = ST_FETCH;
                        pc_d    = pc_inc;
                    end
                    OP_MOV:                        state_d = ST_READ_B;
                    OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = ST_READ_A;
                    OP_LDI:                        state_d = ST_WB;
                    OP_JMP: begin
                        state_d = ST_FETCH;
                        pc_d    = jmp_target;
                    end
                    OP_JZ: begin
                        state_d = ST_FETCH;
                        pc_d    = z_q ? jmp_target : pc_inc;
                    end
                    OP_HLT: state_d = ST_HALT;
                    default: begin
`ifdef ILLEGAL_OP_HALT_EN
                        state_d = ST_HALT;
                        ill_d   = 1'b1;
`else
                        state_d = ST_FETCH;
                        pc_d    = pc_inc;
`endif
                    end
                endcase
            end
            ST_READ_A: state_d = ST_READ_B;
            ST_READ_B: begin
                if (opc_ir != OP_MOV) begin
                    a_d = bus.rb_out_data;
                end
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                b_d = bus.rb_out_data;
                if (is_alu_op(opc_ir)) begin
                    z_d = alu_zero;
                    c_d = alu_carry;
                end
                state_d = ST_WB;
            end
            ST_WB: begin
                state_d = ST_FETCH;
                pc_d    = pc_inc;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        bus.prog_addr   = pc_q;
        bus.rb_read_en  = (state_q == ST_READ_A) || (state_q == ST_READ_B);
        bus.rb_write_en = (state_q == ST_WB);
        bus.rb_selector = (state_q == ST_READ_B) ? rs : rd;
        bus.rb_in_data  = '0;
        if (state_q == ST_WB) begin
            case (opc_ir)
                OP_LDI:  bus.rb_in_data = imm;
                OP_MOV:  bus.rb_in_data = b_q;
                default: bus.rb_in_data = alu_result;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            z_q     <= z_d;
            c_q     <= c_d;
        end
    end

`ifdef ILLEGAL_OP_HALT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_q <= 1'b0;
        end else begin
            ill_q <= ill_d;
        end
    end
    assign illegal_op = ill_q;
`else
    assign illegal_op = 1'b0;
`endif

    assign zero_flag  = z_q;
    assign carry_flag = c_q;
    assign halted     = (state_q == ST_HALT);
endmodule
